// File: rtl/ir_rx_decoder.sv
// ir_rx_decoder: NEC infrared remote-control frame decoder.
//
// The demodulated receiver output is synchronised, inverted into a "mark"
// (carrier present) signal, and every mark edge is classified by how many
// timing ticks elapsed since the previous edge.  A six-state FSM walks the
// leader, 32 LSB-first data bits and stop mark, then either accepts the frame
// (byte complements check), reports a repeat code, or flags an error.
//
// Ports:
//   clk          system clock
//   rst          synchronous active-high reset
//   ir_rx        asynchronous IR receiver output, low = carrier (mark)
//   rx_en        decoder enable; dropping it mid-frame aborts silently
//   addr         last accepted address byte
//   cmd          last accepted command byte
//   frame_valid  one-cycle pulse on an accepted frame
//   repeat_det   one-cycle pulse on an accepted repeat code
//   frame_err    one-cycle pulse on an aborted or rejected frame
//   busy         high while the FSM is outside IDLE
module ir_rx_decoder #(
  parameter int TICK_DIV   = 675,
  parameter int CHECK_ADDR = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ir_rx,
  input  logic       rx_en,
  output logic [7:0] addr,
  output logic [7:0] cmd,
  output logic       frame_valid,
  output logic       repeat_det,
  output logic       frame_err,
  output logic       busy
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE,
    LEAD_MARK,
    LEAD_SPACE,
    BIT_MARK,
    BIT_SPACE,
    STOP_MARK
  } state_t;

  function automatic logic in_rng(input logic [7:0] d, input logic [7:0] lo,
                                  input logic [7:0] hi);
    return (d >= lo) && (d <= hi);
  endfunction

  state_t      state;
  state_t      state_nxt;

  logic        sync_p0;
  logic        sync_p1;
  logic        lvl_p2;
  logic        mark;
  logic        mark_prev;
  logic        rise;
  logic        fall;
  logic        mark_edge;

  logic [PW-1:0] presc;
  logic        tick;
  logic [7:0]  dur;

  logic [31:0] sr;
  logic [4:0]  idx;
  logic        rep_flag;
  logic        accepted;

  logic        abort;
  logic        timeout;
  logic        d_short;
  logic        d_long;
  logic        d_lead;
  logic        d_hdr;
  logic        d_rpt;
  logic        chk_ok;

  logic        fv_nxt;
  logic        rep_nxt;
  logic        err_nxt;
  logic        shift_en;
  logic        shift_bit;
  logic        rep_set;

  // Synchroniser stage: flops idle high (no carrier) out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
      lvl_p2  <= 1'b1;
    end else begin
      sync_p0 <= ir_rx;
      sync_p1 <= sync_p0;
      lvl_p2  <= sync_p1;
    end
  end

  assign mark      = ~sync_p1;
  assign mark_prev = ~lvl_p2;
  assign rise      = mark & ~mark_prev;
  assign fall      = ~mark & mark_prev;
  assign mark_edge = rise | fall;

  // Timing stage: the edge clears both counters so each interval starts at 0;
  // the FSM classifies dur as it stands in the edge cycle, before the clear.
  assign tick = (presc == PRE_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      presc <= '0;
      dur   <= 8'd0;
    end else begin
      if (mark_edge || tick) presc <= '0;
      else                   presc <= presc + PW'(1);

      if (mark_edge)                   dur <= 8'd0;
      else if (tick && dur != 8'hFF)   dur <= dur + 8'd1;
    end
  end

  assign d_short = in_rng(dur, 8'd6, 8'd14);
  assign d_long  = in_rng(dur, 8'd22, 8'd38);
  assign d_lead  = in_rng(dur, 8'd128, 8'd192);
  assign d_hdr   = in_rng(dur, 8'd64, 8'd96);
  assign d_rpt   = in_rng(dur, 8'd32, 8'd48);

  assign abort   = (state != IDLE) && !rx_en;
  assign timeout = (state != IDLE) && (dur == 8'hFF);
  assign chk_ok  = (sr[31:24] == ~sr[23:16]) &&
                   ((CHECK_ADDR == 0) || (sr[15:8] == ~sr[7:0]));

  // FSM state register stage.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (abort || timeout) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:       if (rise && rx_en) state_nxt = LEAD_MARK;
        LEAD_MARK:  if (fall) state_nxt = d_lead ? LEAD_SPACE : IDLE;
        LEAD_SPACE: if (rise) begin
                      if (d_hdr)      state_nxt = BIT_MARK;
                      else if (d_rpt) state_nxt = STOP_MARK;
                      else            state_nxt = IDLE;
                    end
        BIT_MARK:   if (fall) state_nxt = d_short ? BIT_SPACE : IDLE;
        BIT_SPACE:  if (rise) begin
                      if (d_short || d_long)
                        state_nxt = (idx == 5'd31) ? STOP_MARK : BIT_MARK;
                      else
                        state_nxt = IDLE;
                    end
        STOP_MARK:  if (fall) state_nxt = IDLE;
        default:    state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    fv_nxt    = 1'b0;
    rep_nxt   = 1'b0;
    err_nxt   = 1'b0;
    shift_en  = 1'b0;
    shift_bit = 1'b0;
    rep_set   = 1'b0;
    if (!abort) begin
      if (timeout) begin
        err_nxt = 1'b1;
      end else begin
        case (state)
          LEAD_MARK:  if (fall && !d_lead) err_nxt = 1'b1;
          LEAD_SPACE: if (rise) begin
                        if (d_rpt)       rep_set = 1'b1;
                        else if (!d_hdr) err_nxt = 1'b1;
                      end
          BIT_MARK:   if (fall && !d_short) err_nxt = 1'b1;
          BIT_SPACE:  if (rise) begin
                        if (d_short || d_long) begin
                          shift_en  = 1'b1;
                          shift_bit = d_long;
                        end else begin
                          err_nxt = 1'b1;
                        end
                      end
          STOP_MARK:  if (fall) begin
                        // A repeat only makes sense once a real frame has been seen.
                        if (!d_short)      err_nxt = 1'b1;
                        else if (rep_flag) begin
                          rep_nxt = accepted;
                          err_nxt = !accepted;
                        end else begin
                          fv_nxt  = chk_ok;
                          err_nxt = !chk_ok;
                        end
                      end
          default: ;
        endcase
      end
    end
  end

  // Frame data and output stage: leaving for IDLE discards any partial word.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr          <= 32'd0;
      idx         <= 5'd0;
      rep_flag    <= 1'b0;
      accepted    <= 1'b0;
      addr        <= 8'd0;
      cmd         <= 8'd0;
      frame_valid <= 1'b0;
      repeat_det  <= 1'b0;
      frame_err   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      if (state_nxt == IDLE) begin
        sr       <= 32'd0;
        idx      <= 5'd0;
        rep_flag <= 1'b0;
      end else begin
        if (shift_en) begin
          sr  <= {shift_bit, sr[31:1]};
          idx <= idx + 5'd1;
        end
        if (rep_set) rep_flag <= 1'b1;
      end
      if (fv_nxt) begin
        addr     <= sr[7:0];
        cmd      <= sr[23:16];
        accepted <= 1'b1;
      end
      frame_valid <= fv_nxt;
      repeat_det  <= rep_nxt;
      frame_err   <= err_nxt;
      busy        <= (state_nxt != IDLE);
    end
  end

endmodule

// File: doc/ir_rx_decoder.md
IR_RX_DECODER -- requirements
Module: ir_rx_decoder

Interface
REQ-001 Parameters, one per line:
- TICK_DIV, default 675, clk cycles per timing tick (12 MHz -> 56.25 us tick).
- CHECK_ADDR, default 1, 1 = address complement byte must match.
REQ-002 Ports, one per line:
- clk  input  1  single system clock.
- rst  input  1  reset, synchronous, active-high.
- ir_rx  input  1  asynchronous demodulated IR receiver output; low = carrier present (mark).
- rx_en  input  1  decoder enable.
- addr  output  8  last accepted address byte.
- cmd  output  8  last accepted command byte.
- frame_valid  output  1  one-cycle pulse on an accepted frame.
- repeat_det  output  1  one-cycle pulse on an accepted repeat code.
- frame_err  output  1  one-cycle pulse on an aborted or rejected frame.
- busy  output  1  high while the FSM is outside IDLE.

Function
REQ-003 ir_rx SHALL pass through a 2-flop synchronizer, then be inverted to form mark (1 = carrier); edges SHALL be detected on the synchronized signal.
REQ-004 The prescaler SHALL count 0..TICK_DIV-1 and assert tick for one cycle at wrap; the prescaler SHALL be cleared on every mark edge.
REQ-005 The 8-bit duration counter SHALL increment on tick, saturate at 255, and clear to 0 on every mark edge, after its value has been sampled for classification.
REQ-006 FSM states SHALL be IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, STOP_MARK.
REQ-007 IDLE -> LEAD_MARK on a mark rising edge while rx_en = 1.
REQ-008 LEAD_MARK, on a mark falling edge:
- duration 128..192 -> LEAD_SPACE.
- otherwise -> error.
REQ-009 LEAD_SPACE, on a mark rising edge:
- duration 64..96 -> BIT_MARK, with bit index = 0.
- duration 32..48 -> STOP_MARK, flagged as a repeat.
- otherwise -> error.
REQ-010 BIT_MARK, on a mark falling edge:
- duration 6..14 -> BIT_SPACE.
- otherwise -> error.
REQ-011 BIT_SPACE, on a mark rising edge:
- duration 6..14 shifts in 0.
- duration 22..38 shifts in 1.
- otherwise -> error.
- Bits SHALL be shifted LSB first into a 32-bit register.
- Bit index < 31 -> BIT_MARK with index + 1; bit index = 31 -> STOP_MARK.
REQ-012 STOP_MARK, on a mark falling edge with duration 6..14:
- Repeat flag set -> repeat_det pulse, but only if a frame has been accepted since reset; otherwise frame_err.
- Repeat flag clear -> check byte3 == ~byte2, and byte1 == ~byte0 when CHECK_ADDR = 1. Pass: addr <= byte0, cmd <= byte2, frame_valid pulse. Fail: frame_err pulse, addr and cmd unchanged.
- Both outcomes SHALL return to IDLE.
REQ-013 Timeout: in any non-IDLE state, a duration reaching 255 SHALL cause error.
REQ-014 Error SHALL pulse frame_err for one cycle and return to IDLE; the shift register contents SHALL be discarded.
REQ-015 Pulse latency: frame_valid, repeat_det and frame_err SHALL assert on the cycle after the synchronized edge (or timeout) that completes the frame; at most one pulse SHALL assert per cycle.
REQ-016 A mark rising edge arriving in the same cycle as the IDLE return SHALL be ignored; a new frame starts only from IDLE on a later edge.
REQ-017 rx_en deassertion mid-frame SHALL return the FSM to IDLE on the next cycle with no pulse; addr and cmd SHALL be held.
REQ-018 busy SHALL equal (state != IDLE), registered.

Reset
REQ-019 With rst high at a clk edge:
- FSM = IDLE.
- Synchronizer flops = 1 (no mark).
- Prescaler, duration counter, shift register and bit index = 0.
- addr = 0, cmd = 0.
- frame_valid, repeat_det, frame_err, busy = 0.
- "Frame accepted" flag cleared.
REQ-020 rst asserted mid-frame SHALL abort the frame with no pulse.

Verification
REQ-021 Directed scenarios, TICK_DIV = 675:
- Valid frame: NEC frame addr 0x04, cmd 0x08 (bytes 04 FB 08 F7) -> one frame_valid pulse; addr = 0x04, cmd = 0x08; frame_err never asserts.
- Repeat code: 9 ms mark, 2.25 ms space, 562 us mark after a valid frame -> one repeat_det pulse, addr/cmd unchanged. The same stimulus straight after reset -> frame_err.
- Bad checksum: command complement byte 0xF6 -> frame_err, addr/cmd keep previous values, FSM back in IDLE.
- Abort conditions: leader mark of 5 ms -> frame_err. Input stuck in mark after bit 10 -> frame_err about 14.3 ms (255 ticks) after the last edge.
- Boundaries: bit spaces of exactly 6, 14, 22 and 38 ticks -> accepted. Spaces of 5, 15, 21 and 39 ticks -> frame_err.
- Interruptions: rst pulse at bit 16, then a full valid frame -> no pulse for the aborted frame, then frame_valid. rx_en dropped at bit 20 -> busy falls the next cycle, no pulse.
